// File: rtl/stream_checksum_engine_if.sv
// stream_checksum_engine_if: beat stream in, checksum result out, grouped for the checksum engine
interface stream_checksum_engine_if #(parameter int DATA_WIDTH = 32);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  logic [DATA_WIDTH-1:0] in_data;
  logic [KEEP_WIDTH-1:0] in_keep;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [15:0]           seed;
  logic [15:0]           csum_out;
  logic [15:0]           byte_count;
  logic                  verify_ok;
  logic                  csum_valid;
  logic                  csum_ready;
  modport master (
    output in_data, in_keep, in_valid, in_last, seed, csum_ready,
    input  in_ready, csum_out, byte_count, verify_ok, csum_valid
  );
  modport slave (
    input  in_data, in_keep, in_valid, in_last, seed, csum_ready,
    output in_ready, csum_out, byte_count, verify_ok, csum_valid
  );
endinterface

// File: rtl/stream_checksum_engine.sv
// stream_checksum_engine: streaming RFC 1071 ones-complement checksum with seed, byte count and held result
module stream_checksum_engine #(
  parameter int DATA_WIDTH   = 32,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter bit UDP_ZERO_SUB = 1'b0
) (
  input logic clk,
  input logic reset,
  stream_checksum_engine_if.slave bus
);
  localparam int LANES = DATA_WIDTH / 16;
  localparam logic [1:0] ACCUM = 2'd0, FOLD1 = 2'd1, FOLD2 = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [31:0] acc, lane_sum, fold;
  logic first, csum_valid, verify_ok, accept;
  logic [15:0] csum_out, byte_count, pop, zsub;
  logic [16:0] count_sum;
  logic [DATA_WIDTH-1:0] masked;
  always_comb begin
    masked = '0;
    pop = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      masked[i*8 +: 8] = bus.in_keep[i] ? bus.in_data[i*8 +: 8] : 8'h00;
      pop = pop + 16'(bus.in_keep[i]);
    end
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum = lane_sum + 32'(masked[i*16 +: 16]);
  end
  assign accept    = bus.in_valid && state == ACCUM;
  assign fold      = 32'(acc[15:0]) + 32'(acc[31:16]);
  assign count_sum = 17'(byte_count) + 17'(pop);
  // UDP reserves 0x0000 for "no checksum", so a real zero goes out as 0xFFFF
  assign zsub      = (UDP_ZERO_SUB && fold[15:0] == 16'hFFFF) ? 16'hFFFF : ~fold[15:0];
  assign bus.in_ready   = state == ACCUM;
  assign bus.csum_out   = csum_out;
  assign bus.byte_count = byte_count;
  assign bus.verify_ok  = verify_ok;
  assign bus.csum_valid = csum_valid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ACCUM;
      acc        <= '0;
      first      <= 1'b1;
      byte_count <= '0;
      csum_out   <= '0;
      verify_ok  <= 1'b0;
      csum_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: if (accept) begin
          acc        <= fold + lane_sum + (first ? 32'(bus.seed) : 32'd0);
          byte_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
          first      <= 1'b0;
          if (bus.in_last) state <= FOLD1;
        end
        FOLD1: begin
          acc   <= fold;
          state <= FOLD2;
        end
        FOLD2: begin
          acc        <= fold;
          csum_out   <= zsub;
          verify_ok  <= fold[15:0] == 16'hFFFF;
          csum_valid <= 1'b1;
          state      <= DONE;
        end
        default: if (bus.csum_ready) begin
          csum_valid <= 1'b0;
          acc        <= '0;
          byte_count <= '0;
          first      <= 1'b1;
          state      <= ACCUM;
        end
      endcase
    end
  end
endmodule
